// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl
//   Produces the enable for a downstream latch-based clock-gating cell. The
//   gated domain's clock is stopped after IDLE_CYCLES consecutive idle
//   cycles. It is restarted by a level wake request, and acknowledged
//   WAKE_CYCLES cycles later so the gated clock has time to settle.
//   All outputs are Moore outputs decoded from the state register, so
//   gate_en_out is glitch-free.
//
// Ports
//   clk            free-running clock, rising edge
//   reset_in       synchronous active-high reset
//   activity_in    gated domain busy (ignored while GATED / WAKING)
//   wake_req_in    level wake request, held until wake_ack_out
//   gate_en_out    clock enable to the gate cell (1 = clock running)
//   wake_ack_out   domain clock stable and usable
//   gated_out      status: clock currently gated
//   gate_count_out saturating count of entries into GATED
//
// Build option
//   CLOCK_GATE_CTRL_STATS_EN : when defined, gate_count_out is a live
//   saturating counter. When undefined, no counter exists and the output
//   is tied to zero.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RUN        | clock running, domain usable, ack high
// IDLE_COUNT | clock running, counting consecutive idle cycles
// GATED      | clock stopped, waiting for a wake request
// WAKING     | clock re-enabled, settling before ack

module clock_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              activity_in,
    input  logic              wake_req_in,
    output logic              gate_en_out,
    output logic              wake_ack_out,
    output logic              gated_out,
    output logic [STAT_W-1:0] gate_count_out
);

    if (IDLE_CYCLES < 1) begin : g_bad_idle
        $error("clock_gate_ctrl: IDLE_CYCLES must be >= 1");
    end
    if (WAKE_CYCLES < 1) begin : g_bad_wake
        $error("clock_gate_ctrl: WAKE_CYCLES must be >= 1");
    end

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        IDLE_COUNT = 2'd1,
        GATED      = 2'd2,
        WAKING     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
    logic                idle;

    // A pending wake request counts as activity, so a request arriving on
    // the final idle count aborts gating instead of racing it.
    assign idle = !activity_in && !wake_req_in;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        unique case (state_q)
            RUN: begin
                if (idle) begin
                    state_d    = IDLE_COUNT;
                    idle_cnt_d = '0;
                end
            end
            IDLE_COUNT: begin
                if (!idle) begin
                    state_d    = RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d = GATED;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            GATED: begin
                if (wake_req_in) begin
                    state_d    = WAKING;
                    wake_cnt_d = '0;
                end
            end
            WAKING: begin
                // Runs to completion even if the request is withdrawn.
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d = RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q + WAKE_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q    <= RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    assign gate_en_out  = (state_q != GATED);
    assign wake_ack_out = (state_q == RUN);
    assign gated_out    = (state_q == GATED);

`ifdef CLOCK_GATE_CTRL_STATS_EN
    logic [STAT_W-1:0] gate_count_q;
    logic              gate_evt;

    assign gate_evt = (state_q == IDLE_COUNT) && (state_d == GATED);

    always_ff @(posedge clk) begin
        if (reset_in) begin
            gate_count_q <= '0;
        end else if (gate_evt && (gate_count_q != '1)) begin
            gate_count_q <= gate_count_q + STAT_W'(1);
        end
    end

    assign gate_count_out = gate_count_q;
`else
    assign gate_count_out = '0;
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Testbench for clock_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
// Each step drives inputs, pushes the outputs expected after the next
// rising edge, and records what the DUT shows 1 ns after that edge.
// Each test then drains the two queues pairwise.

module tb_clock_gate_ctrl;

    localparam int IDLE_CYCLES = 4;
    localparam int WAKE_CYCLES = 2;
    localparam int STAT_W      = 16;

    // {gate_en, wake_ack, gated}
    localparam logic [2:0] O_RUN  = 3'b110;
    localparam logic [2:0] O_IC   = 3'b100;
    localparam logic [2:0] O_WAKE = 3'b100;
    localparam logic [2:0] O_GATE = 3'b001;

    typedef struct packed {
        logic [2:0]        o;
        logic [STAT_W-1:0] c;
    } sample_t;

    logic              clk = 1'b0;
    logic              reset_in;
    logic              activity_in;
    logic              wake_req_in;
    logic              gate_en_out;
    logic              wake_ack_out;
    logic              gated_out;
    logic [STAT_W-1:0] gate_count_out;

    sample_t exp_q[$];
    sample_t obs_q[$];
    int      total = 0;
    int      bad   = 0;
    int      gates = 0;

    clock_gate_ctrl #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .WAKE_CYCLES(WAKE_CYCLES),
        .STAT_W     (STAT_W)
    ) dut (
        .clk           (clk),
        .reset_in      (reset_in),
        .activity_in   (activity_in),
        .wake_req_in   (wake_req_in),
        .gate_en_out   (gate_en_out),
        .wake_ack_out  (wake_ack_out),
        .gated_out     (gated_out),
        .gate_count_out(gate_count_out)
    );

    always #5 clk = ~clk;

    function automatic logic [STAT_W-1:0] cexp(int n);
`ifdef CLOCK_GATE_CTRL_STATS_EN
        return STAT_W'(n);
`else
        return '0;
`endif
    endfunction

    task automatic apply(input logic act, input logic req, input logic rst,
                         input logic [2:0] eo, input int n);
        sample_t e;
        sample_t o;
        activity_in = act;
        wake_req_in = req;
        reset_in    = rst;
        e.o = eo;
        e.c = cexp(n);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.o = {gate_en_out, wake_ack_out, gated_out};
        o.c = gate_count_out;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        sample_t e, o;
        int i = 0;
        gates = 0;
        apply(1'b1, 1'b0, 1'b1, O_RUN, gates);
        apply(1'b1, 1'b0, 1'b1, O_RUN, gates);
        apply(1'b1, 1'b0, 1'b0, O_RUN, gates);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset step %0d: got out=%b cnt=%0d need out=%b cnt=%0d", i, o.o, o.c, e.o, e.c);
            end
            i++;
        end
    endtask

    task automatic test_gating();
        sample_t e, o;
        int i = 0;
        for (int k = 0; k < IDLE_CYCLES; k++) apply(1'b0, 1'b0, 1'b0, O_IC, gates);
        gates++;
        apply(1'b0, 1'b0, 1'b0, O_GATE, gates);
        apply(1'b0, 1'b0, 1'b0, O_GATE, gates);
        apply(1'b1, 1'b0, 1'b0, O_GATE, gates);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL gating step %0d: got out=%b cnt=%0d need out=%b cnt=%0d", i, o.o, o.c, e.o, e.c);
            end
            i++;
        end
    endtask

    task automatic test_wake();
        sample_t e, o;
        int i = 0;
        apply(1'b0, 1'b1, 1'b0, O_WAKE, gates);
        apply(1'b0, 1'b1, 1'b0, O_WAKE, gates);
        apply(1'b0, 1'b1, 1'b0, O_RUN,  gates);
        apply(1'b0, 1'b1, 1'b0, O_RUN,  gates);
        for (int k = 0; k < 3; k++) apply(1'b1, 1'b0, 1'b0, O_RUN, gates);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL wake step %0d: got out=%b cnt=%0d need out=%b cnt=%0d", i, o.o, o.c, e.o, e.c);
            end
            i++;
        end
    endtask

    task automatic test_abort();
        sample_t e, o;
        int i = 0;
        for (int k = 0; k < IDLE_CYCLES - 1; k++) apply(1'b0, 1'b0, 1'b0, O_IC, gates);
        apply(1'b1, 1'b0, 1'b0, O_RUN, gates);
        for (int k = 0; k < IDLE_CYCLES; k++) apply(1'b0, 1'b0, 1'b0, O_IC, gates);
        gates++;
        apply(1'b0, 1'b0, 1'b0, O_GATE, gates);
        apply(1'b0, 1'b1, 1'b0, O_WAKE, gates);
        apply(1'b0, 1'b1, 1'b0, O_WAKE, gates);
        apply(1'b0, 1'b1, 1'b0, O_RUN,  gates);
        apply(1'b1, 1'b0, 1'b0, O_RUN,  gates);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL abort step %0d: got out=%b cnt=%0d need out=%b cnt=%0d", i, o.o, o.c, e.o, e.c);
            end
            i++;
        end
    endtask

    task automatic test_wake_on_final();
        sample_t e, o;
        int i = 0;
        for (int k = 0; k < IDLE_CYCLES; k++) apply(1'b0, 1'b0, 1'b0, O_IC, gates);
        apply(1'b0, 1'b1, 1'b0, O_RUN, gates);
        apply(1'b0, 1'b1, 1'b0, O_RUN, gates);
        apply(1'b1, 1'b0, 1'b0, O_RUN, gates);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL final_wake step %0d: got out=%b cnt=%0d need out=%b cnt=%0d", i, o.o, o.c, e.o, e.c);
            end
            i++;
        end
    endtask

    task automatic test_early_drop();
        sample_t e, o;
        int i = 0;
        for (int k = 0; k < IDLE_CYCLES; k++) apply(1'b0, 1'b0, 1'b0, O_IC, gates);
        gates++;
        apply(1'b0, 1'b0, 1'b0, O_GATE, gates);
        apply(1'b0, 1'b1, 1'b0, O_WAKE, gates);
        apply(1'b1, 1'b0, 1'b0, O_WAKE, gates);
        apply(1'b1, 1'b0, 1'b0, O_RUN,  gates);
        apply(1'b1, 1'b0, 1'b0, O_RUN,  gates);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL early_drop step %0d: got out=%b cnt=%0d need out=%b cnt=%0d", i, o.o, o.c, e.o, e.c);
            end
            i++;
        end
    endtask

    task automatic test_reset_mid();
        sample_t e, o;
        int i = 0;
        for (int k = 0; k < IDLE_CYCLES; k++) apply(1'b0, 1'b0, 1'b0, O_IC, gates);
        gates++;
        apply(1'b0, 1'b0, 1'b0, O_GATE, gates);
        apply(1'b0, 1'b1, 1'b0, O_WAKE, gates);
        gates = 0;
        apply(1'b1, 1'b0, 1'b1, O_RUN, gates);
        apply(1'b1, 1'b0, 1'b0, O_RUN, gates);
        for (int k = 0; k < IDLE_CYCLES; k++) apply(1'b0, 1'b0, 1'b0, O_IC, gates);
        gates++;
        apply(1'b0, 1'b0, 1'b0, O_GATE, gates);
        gates = 0;
        apply(1'b0, 1'b0, 1'b1, O_RUN, gates);
        apply(1'b0, 1'b0, 1'b0, O_IC,  gates);
        apply(1'b1, 1'b0, 1'b0, O_RUN, gates);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_mid step %0d: got out=%b cnt=%0d need out=%b cnt=%0d", i, o.o, o.c, e.o, e.c);
            end
            i++;
        end
    endtask

    initial begin
        reset_in    = 1'b1;
        activity_in = 1'b1;
        wake_req_in = 1'b0;
        #2;
        test_reset();
        test_gating();
        test_wake();
        test_abort();
        test_wake_on_final();
        test_early_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_gate_ctrl.md
Name: clock_gate_ctrl

Overview:
- Control-side companion to the team's gated-clock flops: generates the enable that drives a downstream clock-gating cell.
- Watches a domain's activity and gates its clock after a programmable idle period.
- Re-enables the clock on a wake request through a req/ack handshake with a fixed settle time.
- Runs on the free-running clock. `gate_en_out` is registered and glitch-free, intended to feed a latch-based gate cell.

Parameters:
- `IDLE_CYCLES`, 16: consecutive idle cycles tolerated in `IDLE_COUNT` before gating; legal range >= 1.
- `WAKE_CYCLES`, 2: cycles the enable is held before ack is granted; legal range >= 1.
- `STAT_W`, 16: width of the gating-event counter.

Ports:
- `clk`  input  1  free-running clock; all logic on its rising edge.
- `reset_in`  input  1  synchronous, active-high reset.
- `activity_in`  input  1  gated domain busy; ignored while `GATED` or `WAKING`.
- `wake_req_in`  input  1  level wake request; requester holds it high until `wake_ack_out` = 1.
- `gate_en_out`  output  1  clock enable to the gating cell (1 = clock running).
- `wake_ack_out`  output  1  1 when the clock is stable and the domain is usable.
- `gated_out`  output  1  status: 1 while in `GATED`.
- `gate_count_out`  output  `STAT_W`  number of entries into `GATED`; saturating.

Behaviour:
- FSM states: `RUN`, `IDLE_COUNT`, `GATED`, `WAKING`. Moore outputs, decoded from the state register only.
  - `gate_en_out` = (state != `GATED`).
  - `wake_ack_out` = (state == `RUN`).
  - `gated_out` = (state == `GATED`).
- Idle condition: idle = !`activity_in` && !`wake_req_in`.
- Reset (any state, any time): state = `RUN`, idle_cnt = 0, wake_cnt = 0, `gate_count_out` = 0. After reset: `gate_en_out` = 1, `wake_ack_out` = 1, `gated_out` = 0.
- `RUN`:
  - idle → `IDLE_COUNT`, idle_cnt <= 0.
  - otherwise stay in `RUN`.
- `IDLE_COUNT`:
  - not idle → `RUN`, idle_cnt <= 0 (abort; also covers a wake request arriving on the final count).
  - idle and idle_cnt == `IDLE_CYCLES`-1 → `GATED`, `gate_count_out` += 1 (saturates at all ones).
  - otherwise idle_cnt += 1.
- `GATED`:
  - `wake_req_in` → `WAKING`, wake_cnt <= 0.
  - otherwise stay in `GATED`.
- `WAKING`:
  - wake_cnt == `WAKE_CYCLES`-1 → `RUN`.
  - otherwise wake_cnt += 1.
  - Not abortable: dropping `wake_req_in` early still completes to `RUN`.
- Gating latency: idle sampled at edge k and at every edge through k+`IDLE_CYCLES` → `gate_en_out` low after edge k+`IDLE_CYCLES`.
- Wake latency: `wake_req_in` sampled at edge m while `GATED`:
  - `gate_en_out` high after edge m.
  - `wake_ack_out` high after edge m+`WAKE_CYCLES`.
- `wake_req_in` high while in `RUN` holds `RUN`, with ack staying 1.
- Counter widths: idle_cnt = $clog2(`IDLE_CYCLES`+1), wake_cnt = $clog2(`WAKE_CYCLES`+1). No wrap is reachable.
- Elaboration error if `IDLE_CYCLES` < 1 or `WAKE_CYCLES` < 1.

Optional Feature:
- Macro: `CLOCK_GATE_CTRL_STATS_EN`.
- Defined: `gate_count_out` counter is implemented as described above.
- Undefined: no counter register exists; `gate_count_out` is tied to 0. Port list is unchanged either way.

Test Plan:
- Reset: assert `reset_in` for 2 cycles → `gate_en_out`=1, `wake_ack_out`=1, `gated_out`=0, `gate_count_out`=0.
- Gating (`IDLE_CYCLES`=4): `activity_in`=0 and `wake_req_in`=0 from edge 10 → `gate_en_out`=0 and `gated_out`=1 after edge 14; `gate_count_out`=1.
- Abort: as above, but `activity_in`=1 at edge 13 → back to `RUN` after edge 13; `gate_en_out` never drops; a fresh idle run needs another 5 idle samples.
- Wake (`WAKE_CYCLES`=2): `wake_req_in`=1 at edge 20 while `GATED` → `gate_en_out`=1 after edge 20, `wake_ack_out`=1 after edge 22; release req → `RUN` holds while activity is present.
- Simultaneous and early-drop cases:
  - `wake_req_in` rises on the final idle count → `RUN`, no gating, count unchanged.
  - Req dropped during `WAKING` → still `RUN` after `WAKE_CYCLES`.
- Reset mid-op: `reset_in` during `WAKING` and again during `GATED` → `RUN` next cycle, `gate_en_out`=1, count=0. Repeat with the macro undefined → `gate_count_out` stays 0 throughout.
